// File: rtl/fetch_pkg.sv
// Purpose: shared types and helpers for the instruction fetch stage (FSM states, text base, PC legality).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_FAULT  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h0040_0000;

    // Operands are widened to 64 bits so base + 4*words never wraps,
    // even when the text segment ends at the very top of the address space.
    function automatic logic pc_legal(input logic [63:0] pc,
                                      input logic [63:0] base,
                                      input logic [63:0] words);
        return (pc[1:0] == 2'b00) && (pc >= base) && (pc < base + (words << 2));
    endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// Purpose: valid/ready output register holding one fetched instruction with its PC and PC+4.
// Latency: 1 cycle from load to valid; registered outputs only.
// Backpressure: contents hold while valid && !consume; flush drops contents regardless of consume.
// Ports: clk/rst_n; load/flush/consume controls; load_* data in; valid/instr/pc/pc_plus4 out.
module fetch_out_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  flush,
    input  logic                  consume,
    input  logic [DATA_WIDTH-1:0] load_instr,
    input  logic [DATA_WIDTH-1:0] load_pc,
    input  logic [DATA_WIDTH-1:0] load_pc_plus4,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] pc_plus4
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            instr    <= '0;
            pc       <= '0;
            pc_plus4 <= '0;
        end else if (flush) begin
            // Only the valid bit is dropped; stale data is harmless behind valid=0.
            valid <= 1'b0;
        end else if (load) begin
            valid    <= 1'b1;
            instr    <= load_instr;
            pc       <= load_pc;
            pc_plus4 <= load_pc_plus4;
        end else if (valid && consume) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Purpose: owns the PC, drives the combinational ROM address, captures words into a valid/ready output register.
// Latency: 1 cycle PC->if_valid; 1 instruction/cycle while if_ready is high.
// Backpressure: if_ready low freezes the output register and the PC; redirect flushes regardless of if_ready.
// Ports: clk/rst_n; start/halt/redirect_valid/redirect_pc control; rom_addr/rom_q ROM port;
//        if_valid/if_ready/if_instr/if_pc/if_pc_plus4 to decode; fault/fetch_count/state status.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] TEXT_BASE  = DATA_WIDTH'(TEXT_BASE_DEFAULT),
    parameter int                    TEXT_WORDS = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  halt,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic [DATA_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [DATA_WIDTH-1:0] if_instr,
    output logic [DATA_WIDTH-1:0] if_pc,
    output logic [DATA_WIDTH-1:0] if_pc_plus4,
    output logic                  fault,
    output logic [31:0]           fetch_count,
    output logic [1:0]            state
);

    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_next_seq;
    fetch_state_t          state_q;
    logic                  fault_q;
    logic [31:0]           count_q;
    logic                  pc_ok;
    logic                  redirect_take;
    logic                  fetch;

    assign pc_next_seq   = pc_q + DATA_WIDTH'(4);
    assign pc_ok         = pc_legal(64'(pc_q), 64'(TEXT_BASE), 64'(TEXT_WORDS));
    // Redirects are only honoured while the unit is still live.
    assign redirect_take = redirect_valid && ((state_q == ST_IDLE) || (state_q == ST_RUN));
    assign fetch         = (state_q == ST_RUN) && pc_ok && !redirect_valid && !halt &&
                           (!if_valid || if_ready);

    assign rom_addr    = pc_q;
    assign fault       = fault_q;
    assign fetch_count = count_q;
    assign state       = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= TEXT_BASE;
            state_q <= ST_IDLE;
            fault_q <= 1'b0;
            count_q <= '0;
        end else begin
            if (redirect_take) begin
                pc_q <= redirect_pc;
            end else if (fetch) begin
                pc_q <= pc_next_seq;
            end

            if (fetch) begin
                count_q <= count_q + 32'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (halt) begin
                        state_q <= ST_HALTED;
                    end else if (!redirect_valid && !pc_ok) begin
                        // Legality is checked at fetch time, so a bad redirect target
                        // is only caught on the cycle after it is loaded.
                        state_q <= ST_FAULT;
                        fault_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    fetch_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (fetch),
        .flush        (redirect_take),
        .consume      (if_ready),
        .load_instr   (rom_q),
        .load_pc      (pc_q),
        .load_pc_plus4(pc_next_seq),
        .valid        (if_valid),
        .instr        (if_instr),
        .pc           (if_pc),
        .pc_plus4     (if_pc_plus4)
    );

endmodule
